// File: rtl/xcore_gnrl_rr_arbiter_if.sv
// Valid/ready bundle between REQ_NUM source channels and one arbitrated output channel.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric.
interface xcore_gnrl_rr_arbiter_if #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [REQ_NUM-1:0]        in_valid;
    logic [REQ_NUM-1:0]        in_last;
    logic [REQ_NUM*DATA_W-1:0] in_data;
    logic [REQ_NUM-1:0]        in_ready;
    logic                      out_valid;
    logic                      out_last;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_id
    );

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_id
    );
endinterface

// File: rtl/xcore_gnrl_rr_arbiter.sv
// Packet-locking valid/ready arbiter: round-robin or fixed priority across REQ_NUM channels,
// with a zero-latency combinational datapath and the grant held until a last beat.
module xcore_gnrl_rr_arbiter #(
    parameter int REQ_NUM   = 4,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    xcore_gnrl_rr_arbiter_if.slave       bus
);
    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   sel_nxt;
    logic               fire;

    // Descending scan so the candidate closest to the priority origin is assigned last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (PRIO_MODE != 0) idx = k;
            else                idx = (int'(ptr_q) + k) % REQ_NUM;
            if (bus.in_valid[idx]) winner = PTR_W'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        sel_nxt = (sel == PTR_W'(REQ_NUM - 1)) ? '0 : sel + 1'b1;
        if (fire) begin
            if (bus.in_last[sel]) begin
                state_d = IDLE;
                ptr_d   = sel_nxt;
            end else if (state_q == IDLE) begin
                state_d = LOCK;
                owner_d = sel;
            end
        end
    end

    always_comb begin
        sel           = (state_q == LOCK) ? owner_q : winner;
        bus.out_data  = bus.in_data[sel*DATA_W +: DATA_W];
        bus.out_last  = bus.in_last[sel];
        bus.out_id    = ID_W'(sel);
        bus.out_valid = 1'b0;
        bus.in_ready  = '0;
        if (!rst) begin
            bus.out_valid     = (state_q == LOCK) ? bus.in_valid[owner_q] : |bus.in_valid;
            bus.in_ready[sel] = bus.out_ready;
        end
        fire = bus.out_valid & bus.out_ready;
    end
endmodule

// File: tb/tb_xcore_gnrl_rr_arbiter.sv
// Directed bench for the packet-locking arbiter: RR, fixed-priority and REQ_NUM=2/5 variants.
module tb_xcore_gnrl_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    xcore_gnrl_rr_arbiter_if #(.REQ_NUM(4), .DATA_W(32), .ID_W(2)) m  ();
    xcore_gnrl_rr_arbiter_if #(.REQ_NUM(4), .DATA_W(32), .ID_W(2)) f  ();
    xcore_gnrl_rr_arbiter_if #(.REQ_NUM(2), .DATA_W(8),  .ID_W(1)) a2 ();
    xcore_gnrl_rr_arbiter_if #(.REQ_NUM(5), .DATA_W(8),  .ID_W(3)) a5 ();

    xcore_gnrl_rr_arbiter #(.REQ_NUM(4), .DATA_W(32), .PRIO_MODE(0), .ID_W(2))
        u_m  (.clk(clk), .rst(rst), .bus(m.slave));
    xcore_gnrl_rr_arbiter #(.REQ_NUM(4), .DATA_W(32), .PRIO_MODE(1), .ID_W(2))
        u_f  (.clk(clk), .rst(rst), .bus(f.slave));
    xcore_gnrl_rr_arbiter #(.REQ_NUM(2), .DATA_W(8),  .PRIO_MODE(0), .ID_W(1))
        u_a2 (.clk(clk), .rst(rst), .bus(a2.slave));
    xcore_gnrl_rr_arbiter #(.REQ_NUM(5), .DATA_W(8),  .PRIO_MODE(0), .ID_W(3))
        u_a5 (.clk(clk), .rst(rst), .bus(a5.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        chk("onehot_m",  32'($onehot0(m.in_ready)),  32'd1);
        chk("onehot_f",  32'($onehot0(f.in_ready)),  32'd1);
        chk("onehot_a2", 32'($onehot0(a2.in_ready)), 32'd1);
        chk("onehot_a5", 32'($onehot0(a5.in_ready)), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m.in_valid  = 4'b1111;  m.in_last = 4'b1111;  m.out_ready = 1'b1;
        m.in_data   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        f.in_valid  = '0;  f.in_last = 4'b1111;  f.out_ready = 1'b1;
        f.in_data   = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        a2.in_valid = '0;  a2.in_last = '1;  a2.out_ready = 1'b1;
        a2.in_data  = {8'h21, 8'h20};
        a5.in_valid = '0;  a5.in_last = '1;  a5.out_ready = 1'b1;
        a5.in_data  = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
        #1;

        // Reset holds outputs quiet regardless of requests
        chk("rst_out_valid", 32'(m.out_valid), 32'd0);
        chk("rst_in_ready",  32'(m.in_ready),  32'd0);
        tick();
        tick();
        chk("rst_out_valid2", 32'(m.out_valid), 32'd0);
        chk("rst_in_ready2",  32'(m.in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("rel_out_id",    32'(m.out_id),    32'd0);
        chk("rel_out_valid", 32'(m.out_valid), 32'd1);

        // Round-robin rotation with single-beat packets
        for (int i = 0; i < 5; i++) begin
            chk("rr_id",    32'(m.out_id),   32'(i % 4));
            chk("rr_data",  m.out_data,      32'hD0 + 32'(i % 4));
            chk("rr_ready", 32'(m.in_ready), 32'(1 << (i % 4)));
            tick();
        end

        // Packet lock on ch1 (ptr now 1) with ch0/ch2 competing
        m.in_valid = 4'b0111;  m.in_last = 4'b1101;  #1;
        chk("lock_b1_id", 32'(m.out_id), 32'd1);
        tick();
        chk("lock_b2_id",    32'(m.out_id),   32'd1);
        chk("lock_b2_ready", 32'(m.in_ready), 32'b0010);
        tick();
        m.in_last = 4'b1111;  #1;
        chk("lock_b3_id",    32'(m.out_id),   32'd1);
        chk("lock_b3_ready", 32'(m.in_ready), 32'b0010);
        chk("lock_b3_last",  32'(m.out_last), 32'd1);
        tick();
        chk("after_lock_id", 32'(m.out_id), 32'd2);

        // Backpressure on ch3: nothing moves until out_ready returns
        m.in_valid = 4'b1000;  m.out_ready = 1'b0;  #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(m.out_valid), 32'd1);
            chk("bp_data",  m.out_data,       32'hD3);
            chk("bp_ready", 32'(m.in_ready),  32'd0);
            tick();
        end
        m.in_valid = 4'b1111;  #1;
        chk("bp_ptr_kept", 32'(m.out_id), 32'd2);
        m.in_valid = 4'b1000;  m.out_ready = 1'b1;  #1;
        chk("bp_accept", 32'(m.in_ready), 32'b1000);
        tick();
        m.in_valid = 4'b1111;  #1;
        chk("wrap_id", 32'(m.out_id), 32'd0);

        // Owner stall, then reset mid-packet on ch2
        m.in_valid = 4'b0100;  m.in_last = 4'b1011;  #1;
        chk("mid_b1_id", 32'(m.out_id), 32'd2);
        tick();
        m.in_valid = 4'b0011;  #1;
        chk("stall_valid", 32'(m.out_valid), 32'd0);
        chk("stall_id",    32'(m.out_id),    32'd2);
        m.in_valid = 4'b0111;  #1;
        chk("mid_b2_id",    32'(m.out_id),   32'd2);
        chk("mid_b2_ready", 32'(m.in_ready), 32'b0100);
        rst = 1'b1;  #1;
        chk("mid_rst_valid", 32'(m.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(m.in_ready),  32'd0);
        tick();
        rst = 1'b0;  m.in_valid = 4'b0110;  #1;
        chk("post_rst_id",    32'(m.out_id),   32'd1);
        chk("post_rst_ready", 32'(m.in_ready), 32'b0010);
        m.in_valid = '0;  m.in_last = 4'b1111;

        // Fixed priority: ch0 always beats ch2
        f.in_valid = 4'b0101;  #1;
        for (int i = 0; i < 4; i++) begin
            chk("fix_id",    32'(f.out_id),   32'd0);
            chk("fix_ready", 32'(f.in_ready), 32'b0001);
            chk("fix_data",  f.out_data,      32'hF0);
            tick();
        end
        f.in_valid = '0;

        // REQ_NUM=2 rotation
        a2.in_valid = 2'b11;  #1;
        for (int i = 0; i < 4; i++) begin
            chk("r2_id",   32'(a2.out_id),   32'(i % 2));
            chk("r2_data", 32'(a2.out_data), 32'h20 + 32'(i % 2));
            tick();
        end
        a2.in_valid = '0;

        // REQ_NUM=5 rotation, wrap at index 4
        a5.in_valid = 5'b11111;  #1;
        for (int i = 0; i < 6; i++) begin
            chk("r5_id",   32'(a5.out_id),   32'(i % 5));
            chk("r5_data", 32'(a5.out_data), 32'h50 + 32'(i % 5));
            tick();
        end
        a5.in_valid = 5'b10001;  #1;
        chk("r5_skip_id", 32'(a5.out_id), 32'd4);
        tick();
        chk("r5_wrap_id", 32'(a5.out_id), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
